// File: rtl/combat_resolver.sv
// combat_resolver
//   Two-player hit/shield resolution with a FIGHT/KO match state machine.
//   Each cycle in FIGHT, both attack requests are evaluated against range,
//   facing and the defender's action. Health, shield and hit_event update one
//   clock edge after the sampled request. A free-running counter periodically
//   recharges shields. Reaching zero health moves the match to KO, where
//   everything is frozen until a restart pulse.
//
//   Optional feature: define COMBAT_CHIP_DAMAGE_EN so that a fully blocked
//   hit also removes 1 health point (saturating, can cause KO).
//
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   p0_attack_request/p1_attack_request one-cycle attack pulse per player
//   p0_action/p1_action [6:0]           bit 6 facing (0 right, 1 left),
//                                       bits 5:0 one-hot {STANDING,PUNCHING,
//                                       JUMPING,SHIELDING,CROUCHING,WALKING}
//   p0_x/p1_x [9:0]                     horizontal positions (pixels)
//   restart                             rematch pulse, honoured only in KO
//   p0/p1_health, p0/p1_shield [7:0]    registered current values
//   hit_event [1:0]                     bit n: player n took a connected hit
//   game_over, winner, draw             match result flags
module combat_resolver #(
    parameter logic [7:0]  DAMAGE          = 8'd10,
    parameter logic [7:0]  SHIELD_COST     = 8'd20,
    parameter logic [9:0]  HIT_RANGE       = 10'd40,
    parameter logic [31:0] RECHARGE_PERIOD = 32'd12_500_000,
    parameter logic [7:0]  MAX_HEALTH      = 8'd100,
    parameter logic [7:0]  MAX_SHIELD      = 8'd100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_attack_request,
    input  logic       p1_attack_request,
    input  logic [6:0] p0_action,
    input  logic [6:0] p1_action,
    input  logic [9:0] p0_x,
    input  logic [9:0] p1_x,
    input  logic       restart,
    output logic [7:0] p0_health,
    output logic [7:0] p1_health,
    output logic [7:0] p0_shield,
    output logic [7:0] p1_shield,
    output logic [1:0] hit_event,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);

    typedef enum logic {FIGHT, KO} state_t;

    localparam int unsigned ACT_FACING    = 6;
    localparam int unsigned ACT_JUMPING   = 3;
    localparam int unsigned ACT_SHIELDING = 2;

    state_t      state_q, state_d;
    logic [31:0] recharge_cnt;
    logic        recharge_wrap;
    logic [9:0]  distance;
    logic        in_range;
    logic        p0_faces_p1, p1_faces_p0;
    logic        hit_on_p0, hit_on_p1;
    logic [7:0]  p0_health_n, p1_health_n, p0_shield_n, p1_shield_n;

    // Only facing, JUMPING and SHIELDING bits influence resolution.
    logic unused_action_bits;
    assign unused_action_bits = ^{p0_action[5:4], p0_action[1:0],
                                  p1_action[5:4], p1_action[1:0]};

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    // Returns {health, shield} for one defender after this cycle's events.
    function automatic logic [15:0] resolve(input logic [7:0] hp, input logic [7:0] sh,
                                            input logic hit, input logic shielding,
                                            input logic recharge);
        logic [7:0] h;
        logic [7:0] s;
        h = hp;
        s = sh;
        if (hit) begin
            if (shielding) begin
                if (sh >= SHIELD_COST) begin
                    s = sh - SHIELD_COST;
`ifdef COMBAT_CHIP_DAMAGE_EN
                    h = sat_sub(hp, 8'd1);
`endif
                end else begin
                    s = '0;
                    h = sat_sub(hp, DAMAGE >> 1);
                end
            end else begin
                h = sat_sub(hp, DAMAGE);
            end
        end else if (recharge && !shielding && sh < MAX_SHIELD) begin
            s = sh + 8'd1;
        end
        return {h, s};
    endfunction

    always_comb begin
        distance      = (p0_x >= p1_x) ? p0_x - p1_x : p1_x - p0_x;
        in_range      = (distance <= HIT_RANGE);
        // Equal positions satisfy both facing directions.
        p0_faces_p1   = p0_action[ACT_FACING] ? (p1_x <= p0_x) : (p1_x >= p0_x);
        p1_faces_p0   = p1_action[ACT_FACING] ? (p0_x <= p1_x) : (p0_x >= p1_x);
        hit_on_p1     = (state_q == FIGHT) && p0_attack_request && in_range &&
                        p0_faces_p1 && !p1_action[ACT_JUMPING];
        hit_on_p0     = (state_q == FIGHT) && p1_attack_request && in_range &&
                        p1_faces_p0 && !p0_action[ACT_JUMPING];
        recharge_wrap = (recharge_cnt == RECHARGE_PERIOD - 32'd1);
        {p0_health_n, p0_shield_n} = resolve(p0_health, p0_shield, hit_on_p0,
                                             p0_action[ACT_SHIELDING], recharge_wrap);
        {p1_health_n, p1_shield_n} = resolve(p1_health, p1_shield, hit_on_p1,
                                             p1_action[ACT_SHIELDING], recharge_wrap);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FIGHT: if (p0_health_n == '0 || p1_health_n == '0) state_d = KO;
            KO:    if (restart) state_d = FIGHT;
            default: state_d = FIGHT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FIGHT;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_health    <= MAX_HEALTH;
            p1_health    <= MAX_HEALTH;
            p0_shield    <= MAX_SHIELD;
            p1_shield    <= MAX_SHIELD;
            recharge_cnt <= '0;
            hit_event    <= '0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            draw         <= 1'b0;
        end else if (state_q == FIGHT) begin
            p0_health    <= p0_health_n;
            p1_health    <= p1_health_n;
            p0_shield    <= p0_shield_n;
            p1_shield    <= p1_shield_n;
            hit_event    <= {hit_on_p1, hit_on_p0};
            recharge_cnt <= recharge_wrap ? '0 : recharge_cnt + 32'd1;
            if (state_d == KO) begin
                game_over <= 1'b1;
                draw      <= (p0_health_n == '0) && (p1_health_n == '0);
                winner    <= (p0_health_n == '0) && (p1_health_n != '0);
            end
        end else begin
            hit_event <= '0;
            if (restart) begin
                p0_health    <= MAX_HEALTH;
                p1_health    <= MAX_HEALTH;
                p0_shield    <= MAX_SHIELD;
                p1_shield    <= MAX_SHIELD;
                recharge_cnt <= '0;
                game_over    <= 1'b0;
                winner       <= 1'b0;
                draw         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_combat_resolver.sv
module tb_combat_resolver;

    localparam logic [6:0] STAND_R  = 7'b0_100000;
    localparam logic [6:0] STAND_L  = 7'b1_100000;
    localparam logic [6:0] SHIELD_R = 7'b0_000100;
    localparam logic [6:0] SHIELD_L = 7'b1_000100;
    localparam logic [6:0] JUMP_L   = 7'b1_001000;
`ifdef COMBAT_CHIP_DAMAGE_EN
    localparam int CHIP = 1;
`else
    localparam int CHIP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, p0_attack_request, p1_attack_request, restart;
    logic [6:0] p0_action, p1_action;
    logic [9:0] p0_x, p1_x;
    logic [7:0] p0_health, p1_health, p0_shield, p1_shield;
    logic [1:0] hit_event;
    logic       game_over, winner, draw;
    logic [7:0] rc_p0_health, rc_p1_health, rc_p0_shield, rc_p1_shield;
    logic [1:0] rc_hit_event;
    logic       rc_game_over, rc_winner, rc_draw;

    int checks = 0;
    int errors = 0;
    int exp_h1;

    always #5 clk = ~clk;

    combat_resolver dut (
        .clk(clk), .reset(reset),
        .p0_attack_request(p0_attack_request), .p1_attack_request(p1_attack_request),
        .p0_action(p0_action), .p1_action(p1_action), .p0_x(p0_x), .p1_x(p1_x),
        .restart(restart),
        .p0_health(p0_health), .p1_health(p1_health),
        .p0_shield(p0_shield), .p1_shield(p1_shield),
        .hit_event(hit_event), .game_over(game_over), .winner(winner), .draw(draw)
    );

    combat_resolver #(.RECHARGE_PERIOD(32'd4)) dut_rc (
        .clk(clk), .reset(reset),
        .p0_attack_request(p0_attack_request), .p1_attack_request(p1_attack_request),
        .p0_action(p0_action), .p1_action(p1_action), .p0_x(p0_x), .p1_x(p1_x),
        .restart(restart),
        .p0_health(rc_p0_health), .p1_health(rc_p1_health),
        .p0_shield(rc_p0_shield), .p1_shield(rc_p1_shield),
        .hit_event(rc_hit_event), .game_over(rc_game_over), .winner(rc_winner), .draw(rc_draw)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; p0_attack_request = 1'b0; p1_attack_request = 1'b0; restart = 1'b0;
        p0_action = STAND_R; p1_action = STAND_L; p0_x = 10'd100; p1_x = 10'd130;
        step();
        do_reset();

        // Reset state
        check("rst_p0_health", p0_health, 100);
        check("rst_p1_health", p1_health, 100);
        check("rst_p0_shield", p0_shield, 100);
        check("rst_p1_shield", p1_shield, 100);
        check("rst_hit_event", hit_event, 0);
        check("rst_flags", {game_over, winner, draw}, 0);

        // Unblocked hit p0 -> p1
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        check("hit_p1_health", p1_health, 90);
        check("hit_p0_health", p0_health, 100);
        check("hit_event_p1", hit_event, 2'b10);
        step();
        check("hit_event_clear", hit_event, 0);

        // Unblocked hit p1 -> p0
        p1_attack_request = 1'b1; step(); p1_attack_request = 1'b0;
        check("hit_p0_by_p1", p0_health, 90);
        check("hit_event_p0", hit_event, 2'b01);

        // Blocks until shield exhausted, then a partially blocked hit
        do_reset();
        p1_action = SHIELD_L;
        for (int i = 1; i <= 5; i++) begin
            p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
            check("block_shield", p1_shield, 100 - 20 * i);
            check("block_health", p1_health, 100 - CHIP * i);
            check("block_hit_event", hit_event, 2'b10);
        end
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        check("empty_shield", p1_shield, 0);
        check("half_damage", p1_health, 95 - 5 * CHIP);
        exp_h1 = 95 - 5 * CHIP;

        // Range / facing / jumping conditions
        p1_action = STAND_L;
        p1_x = 10'd141;
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        check("range41_health", p1_health, exp_h1);
        check("range41_event", hit_event, 0);
        p1_x = 10'd140;
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        exp_h1 -= 10;
        check("range40_health", p1_health, exp_h1);
        check("range40_event", hit_event, 2'b10);
        p1_x = 10'd130; p0_action = STAND_L;
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        check("facing_away_health", p1_health, exp_h1);
        check("facing_away_event", hit_event, 0);
        p0_action = STAND_R; p1_action = JUMP_L;
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        check("jump_health", p1_health, exp_h1);
        check("jump_event", hit_event, 0);
        p1_action = STAND_L; p1_x = 10'd100; p0_action = STAND_L;
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        exp_h1 -= 10;
        check("equal_pos_health", p1_health, exp_h1);
        p0_action = STAND_R; p1_x = 10'd130;

        // Simultaneous KO -> draw
        do_reset();
        p0_attack_request = 1'b1; p1_attack_request = 1'b1;
        repeat (9) step();
        check("sim_p0_at10", p0_health, 10);
        check("sim_p1_at10", p1_health, 10);
        check("sim_not_over", game_over, 0);
        step();
        check("draw_p0_health", p0_health, 0);
        check("draw_p1_health", p1_health, 0);
        check("draw_event", hit_event, 2'b11);
        check("draw_flags", {game_over, winner, draw}, 3'b101);
        step();
        check("ko_ignore_event", hit_event, 0);
        check("ko_ignore_health", {p0_health, p1_health}, 0);
        check("ko_held", game_over, 1);
        p0_attack_request = 1'b0; p1_attack_request = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        check("restart_health", {p0_health, p1_health}, 16'h6464);
        check("restart_shield", {p0_shield, p1_shield}, 16'h6464);
        check("restart_flags", {game_over, winner, draw}, 0);

        // Restart in FIGHT is ignored
        p0_attack_request = 1'b1; step(); p0_attack_request = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        check("restart_fight_ignored", p1_health, 90);

        // Single KO, winner 0, then reset in KO
        do_reset();
        p0_attack_request = 1'b1;
        repeat (10) step();
        p0_attack_request = 1'b0;
        check("ko0_p1_health", p1_health, 0);
        check("ko0_flags", {game_over, winner, draw}, 3'b100);
        do_reset();
        check("ko_reset_flags", {game_over, winner, draw}, 0);
        check("ko_reset_health", {p0_health, p1_health}, 16'h6464);

        // Single KO, winner 1
        p1_attack_request = 1'b1;
        repeat (10) step();
        p1_attack_request = 1'b0;
        check("ko1_flags", {game_over, winner, draw}, 3'b110);
        check("ko1_p1_health", p1_health, 100);

        // Recharge (period 4 instance)
        reset = 1'b1; p0_action = SHIELD_R; step();
        reset = 1'b0; p1_attack_request = 1'b1; step(); p1_attack_request = 1'b0;
        check("rc_block", rc_p0_shield, 80);
        repeat (3) step();
        check("rc_shielding_no_inc", rc_p0_shield, 80);
        p0_action = STAND_R;
        repeat (3) step();
        check("rc_before_wrap", rc_p0_shield, 80);
        step();
        check("rc_first_inc", rc_p0_shield, 81);
        repeat (75) step();
        check("rc_99", rc_p0_shield, 99);
        step();
        check("rc_100", rc_p0_shield, 100);
        repeat (8) step();
        check("rc_saturate", rc_p0_shield, 100);
        check("rc_p1_saturate", rc_p1_shield, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
